pc_fetch_sequencer: RTL and testbench

//  Owns the architectural PC register and sequences the pci incrementer to drive instruction fetch.

---
 rtl/pc_fetch_sequencer_pkg.sv | 19 +
 rtl/pc_fetch_sequencer_pci.sv | 22 ++
 rtl/pc_fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
//============================================================================
// Module : cl_fetch_pkg
// Brief  : Shared types for the instruction-fetch front end.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package cl_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_sequencer_pci.sv
//============================================================================
// Module : pci
// Brief  : PC incrementer; sequential step of one word or a pc+offset target.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module pci #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 i_select,
    input  logic [REG_WIDTH-1:0] i_pc,
    input  logic [REG_WIDTH-1:0] i_offset,
    output logic [REG_WIDTH-1:0] o_next_pc
);

    // Both paths wrap modulo 2^REG_WIDTH; the offset is two's complement.
    assign o_next_pc = i_select ? (i_pc + i_offset) : (i_pc + REG_WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
//============================================================================
// Module : pc_fetch_sequencer
// Brief  : Owns the PC, issues single-outstanding imem fetches, hands words to
//          decode, and applies hazard stalls and execute-stage redirects.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module pc_fetch_sequencer
    import cl_fetch_pkg::*;
#(
    parameter int                   REG_WIDTH = 32,
    parameter logic [REG_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_stall,
    input  logic                 i_branch_valid,
    input  logic [REG_WIDTH-1:0] i_branch_pc,
    input  logic [REG_WIDTH-1:0] i_branch_offset,
    output logic                 o_imem_req,
    output logic [REG_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [REG_WIDTH-1:0] i_imem_rdata,
    output logic                 o_fetch_valid,
    output logic [REG_WIDTH-1:0] o_fetch_pc,
    output logic [REG_WIDTH-1:0] o_fetch_instr,
    input  logic                 i_fetch_ready,
    output logic                 o_flush
);

    fetch_state_e         state_q, state_d;
    logic [REG_WIDTH-1:0] pc_q, pc_d;
    logic [REG_WIDTH-1:0] instr_q, instr_d;
    logic                 discard_q, discard_d;
    logic                 flush_q, flush_d;

    logic                 w_redirect;
    logic [REG_WIDTH-1:0] w_pci_pc;
    logic [REG_WIDTH-1:0] w_pci_next;

    assign w_redirect = i_branch_valid;
    assign w_pci_pc   = w_redirect ? i_branch_pc : pc_q;

    pci #(
        .REG_WIDTH (REG_WIDTH)
    ) u_pci (
        .i_select  (w_redirect),
        .i_pc      (w_pci_pc),
        .i_offset  (i_branch_offset),
        .o_next_pc (w_pci_next)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        discard_d = discard_q;
        flush_d   = w_redirect;

        if (w_redirect) begin
            pc_d      = w_pci_next;
            discard_d = 1'b0;
            if (i_enable) begin
                state_d = FS_REQ;
            end else begin
                state_d = FS_IDLE;
            end
            // A granted or still-pending request must drain before refetching;
            // a response arriving with the redirect is simply not captured.
            if (state_q == FS_REQ && i_imem_gnt) begin
                state_d   = FS_WAIT;
                discard_d = 1'b1;
            end else if (state_q == FS_WAIT && !i_imem_rvalid) begin
                state_d   = FS_WAIT;
                discard_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                FS_IDLE: begin
                    if (i_enable) begin
                        state_d = FS_REQ;
                    end
                end
                FS_REQ: begin
                    if (i_imem_gnt) begin
                        state_d = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            if (i_enable) begin
                                state_d = FS_REQ;
                            end else begin
                                state_d = FS_IDLE;
                            end
                        end else begin
                            instr_d = i_imem_rdata;
                            state_d = FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (i_fetch_ready && !i_stall) begin
                        pc_d = w_pci_next;
                        if (i_enable) begin
                            state_d = FS_REQ;
                        end else begin
                            state_d = FS_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = FS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= FS_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            discard_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            discard_q <= discard_d;
            flush_q   <= flush_d;
        end
    end

    assign o_imem_req    = (state_q == FS_REQ);
    assign o_imem_addr   = pc_q;
    assign o_fetch_valid = (state_q == FS_HOLD);
    assign o_fetch_pc    = pc_q;
    assign o_fetch_instr = instr_q;
    assign o_flush       = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
//============================================================================
// Module : tb_pc_fetch_sequencer
// Brief  : Self-checking bench: directed fetch scenarios plus random traffic
//          against a transaction-level reference model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_stall = 1'b0;
    logic          i_branch_valid = 1'b0;
    logic [W-1:0]  i_branch_pc = '0;
    logic [W-1:0]  i_branch_offset = '0;
    logic          o_imem_req;
    logic [W-1:0]  o_imem_addr;
    logic          i_imem_gnt = 1'b0;
    logic          i_imem_rvalid = 1'b0;
    logic [W-1:0]  i_imem_rdata = '0;
    logic          o_fetch_valid;
    logic [W-1:0]  o_fetch_pc;
    logic [W-1:0]  o_fetch_instr;
    logic          i_fetch_ready = 1'b0;
    logic          o_flush;

    always #5 i_clk = ~i_clk;

    pc_fetch_sequencer #(
        .REG_WIDTH (W),
        .RESET_PC  (RPC)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_branch_valid  (i_branch_valid),
        .i_branch_pc     (i_branch_pc),
        .i_branch_offset (i_branch_offset),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_gnt      (i_imem_gnt),
        .i_imem_rvalid   (i_imem_rvalid),
        .i_imem_rdata    (i_imem_rdata),
        .o_fetch_valid   (o_fetch_valid),
        .o_fetch_pc      (o_fetch_pc),
        .o_fetch_instr   (o_fetch_instr),
        .i_fetch_ready   (i_fetch_ready),
        .o_flush         (o_flush)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Reference model: one flag per pipeline phase, none set means idle.
    bit          m_req, m_wait, m_valid, m_drop, m_flush;
    logic [31:0] m_pc, m_instr;

    // Memory responder bookkeeping.
    bit          pend;
    logic [31:0] pend_addr;
    bit          s_req;
    logic [31:0] s_addr;

    task automatic model_reset();
        m_req = 0; m_wait = 0; m_valid = 0; m_drop = 0; m_flush = 0;
        m_pc = RPC; m_instr = '0;
        pend = 0;
    endtask

    task automatic model_step();
        bit          n_req, n_wait, n_valid, n_drop;
        logic [31:0] n_pc, n_instr;
        n_req = m_req; n_wait = m_wait; n_valid = m_valid; n_drop = m_drop;
        n_pc = m_pc; n_instr = m_instr;
        if (i_branch_valid) begin
            n_pc = i_branch_pc + i_branch_offset;
            if (m_wait && !i_imem_rvalid) begin
                n_drop = 1;
            end else if (m_req && i_imem_gnt) begin
                n_req = 0; n_wait = 1; n_drop = 1;
            end else begin
                n_req = i_enable; n_wait = 0; n_valid = 0; n_drop = 0;
            end
        end else if (m_req) begin
            if (i_imem_gnt) begin n_req = 0; n_wait = 1; end
        end else if (m_wait) begin
            if (i_imem_rvalid) begin
                n_wait = 0;
                if (m_drop) begin
                    n_drop = 0; n_req = i_enable;
                end else begin
                    n_instr = i_imem_rdata; n_valid = 1;
                end
            end
        end else if (m_valid) begin
            if (i_fetch_ready && !i_stall) begin
                n_pc = m_pc + 32'd1; n_valid = 0; n_req = i_enable;
            end
        end else if (i_enable) begin
            n_req = 1;
        end
        m_flush = i_branch_valid;
        m_req = n_req; m_wait = n_wait; m_valid = n_valid; m_drop = n_drop;
        m_pc = n_pc; m_instr = n_instr;
    endtask

    task automatic compare_all();
        check_eq("imem_req",    32'(o_imem_req),    32'(m_req));
        check_eq("imem_addr",   o_imem_addr,        m_pc);
        check_eq("fetch_valid", 32'(o_fetch_valid), 32'(m_valid));
        check_eq("fetch_pc",    o_fetch_pc,         m_pc);
        check_eq("fetch_instr", o_fetch_instr,      m_instr);
        check_eq("flush",       32'(o_flush),       32'(m_flush));
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (!i_rst_n) begin
            model_reset();
        end else begin
            model_step();
            if (i_imem_rvalid) pend = 0;
            if (s_req && i_imem_gnt) begin pend = 1; pend_addr = s_addr; end
        end
        #1;
        cyc++;
        compare_all();
        s_req  = o_imem_req;
        s_addr = o_imem_addr;
    endtask

    task automatic drive(input bit g, input bit rv, input logic [31:0] d);
        i_imem_gnt = g; i_imem_rvalid = rv; i_imem_rdata = d;
    endtask

    // mode 0: immediate gnt and rvalid; 1: random timing; 2: gnt only.
    task automatic drive_mem(input int mode);
        bit g, rv;
        case (mode)
            0: begin g = o_imem_req; rv = pend; end
            1: begin
                g  = o_imem_req ? ($urandom % 3 != 0) : ($urandom % 8 == 0);
                rv = pend && ($urandom % 3 == 0);
            end
            default: begin g = o_imem_req; rv = 0; end
        endcase
        drive(g, rv, rv ? mem(pend_addr) : $urandom);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_fetch_valid && n < 30) begin
            drive_mem(0); tick(); n++;
        end
        drive(0, 0, 0);
        check_eq(tag, 32'(o_fetch_valid), 32'd1);
    endtask

    task automatic branch(input logic [31:0] bpc, input logic [31:0] off);
        i_branch_valid = 1; i_branch_pc = bpc; i_branch_offset = off;
        tick();
        i_branch_valid = 0;
    endtask

    initial begin
        int acc, req_cyc;
        bit prev_req, prev_valid;
        model_reset();
        s_req = 0; s_addr = '0;

        // Reset values
        repeat (3) tick();
        check_eq("rst_req",   32'(o_imem_req),    32'd0);
        check_eq("rst_addr",  o_imem_addr,        RPC);
        check_eq("rst_valid", 32'(o_fetch_valid), 32'd0);
        check_eq("rst_pc",    o_fetch_pc,         RPC);
        check_eq("rst_instr", o_fetch_instr,      32'd0);
        check_eq("rst_flush", 32'(o_flush),       32'd0);
        i_rst_n = 1; i_enable = 1; i_fetch_ready = 1;

        // Linear fetch with two-cycle req-to-valid latency
        acc = 0; req_cyc = 0;
        for (int i = 0; i < 40 && acc < 4; i++) begin
            prev_req = o_imem_req; prev_valid = o_fetch_valid;
            drive_mem(0);
            tick();
            if (o_imem_req && !prev_req) req_cyc = cyc;
            if (o_fetch_valid && !prev_valid) begin
                check_eq("lin_latency", 32'(cyc - req_cyc), 32'd2);
                check_eq("lin_pc", o_fetch_pc, 32'(acc));
                check_eq("lin_instr", o_fetch_instr, mem(32'(acc)));
                acc++;
            end
        end
        check_eq("lin_count", 32'(acc), 32'd4);

        // Redirect while presenting pc 10: target 8 + (-3)
        i_fetch_ready = 0;
        drive_mem(0);
        branch(32'd10, 32'd0);
        wait_valid("hold_wait");
        check_eq("hold_pc", o_fetch_pc, 32'd10);
        i_fetch_ready = 1;
        branch(32'd8, 32'hFFFF_FFFD);
        check_eq("br_flush", 32'(o_flush), 32'd1);
        check_eq("br_valid", 32'(o_fetch_valid), 32'd0);
        check_eq("br_req",   32'(o_imem_req), 32'd1);
        check_eq("br_addr",  o_imem_addr, 32'd5);
        drive_mem(0); tick();
        check_eq("br_flush_end", 32'(o_flush), 32'd0);

        // Redirect in WAIT, stale 0xDEAD response must be dropped
        i_fetch_ready = 0;
        wait_valid("wait_hold");
        i_fetch_ready = 1;
        drive(0, 0, 0); tick();
        drive_mem(2); tick();
        drive(0, 0, 0);
        branch(32'h40, 32'd0);
        drive(0, 1, 32'hDEAD); tick();
        drive(0, 0, 0);
        check_eq("wr_valid", 32'(o_fetch_valid), 32'd0);
        check_eq("wr_req",   32'(o_imem_req), 32'd1);
        check_eq("wr_addr",  o_imem_addr, 32'h40);

        // Redirect coincident with rvalid, then a slow grant
        drive(1, 0, 0); tick();
        drive(0, 1, mem(32'h40));
        branch(32'h80, 32'h10);
        drive(0, 0, 0);
        check_eq("co_flush", 32'(o_flush), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("co_req",  32'(o_imem_req), 32'd1);
            check_eq("co_addr", o_imem_addr, 32'h90);
        end
        drive(1, 0, 0); tick();
        drive(0, 1, mem(32'h90)); tick();
        drive(0, 0, 0);
        check_eq("co_valid", 32'(o_fetch_valid), 32'd1);
        check_eq("co_instr", o_fetch_instr, mem(32'h90));

        // Wrap past all-ones, then disable from HOLD
        i_fetch_ready = 0;
        branch(32'hFFFF_FFFF, 32'd0);
        wait_valid("wrap_hold");
        check_eq("wrap_pc", o_fetch_pc, 32'hFFFF_FFFF);
        i_fetch_ready = 1; tick();
        check_eq("wrap_addr", o_imem_addr, 32'd0);
        wait_valid("dis_hold");
        i_enable = 0; tick();
        check_eq("dis_valid", 32'(o_fetch_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("dis_req", 32'(o_imem_req), 32'd0);
        end

        // Async reset while a response is outstanding
        i_enable = 1;
        drive_mem(2); tick();
        drive_mem(2); tick();
        drive(0, 0, 0);
        #2 i_rst_n = 0;
        model_reset();
        #1;
        check_eq("ar_req",   32'(o_imem_req),    32'd0);
        check_eq("ar_addr",  o_imem_addr,        RPC);
        check_eq("ar_valid", 32'(o_fetch_valid), 32'd0);
        i_enable = 0;
        drive(0, 1, 32'hBAD0); tick();
        i_rst_n = 1;
        drive(0, 1, 32'hBAD1); tick();
        drive(0, 0, 0); tick();
        check_eq("ar_idle_req", 32'(o_imem_req), 32'd0);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            i_enable       = ($urandom % 16 != 0);
            i_stall        = ($urandom % 4 == 0);
            i_fetch_ready  = ($urandom % 3 != 0);
            i_branch_valid = ($urandom % 10 == 0);
            i_branch_pc    = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            i_branch_offset = r[4] ? {{28{r[3]}}, r[3:0]} : $urandom;
            drive_mem(1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
